// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multiply/divide unit that sits beside the
//   pipeline EX stage: operation encodings, the sequencer state type and the
//   default data width.
//   No ports (package).
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   One combinational iteration of the radix-2 multiply / restoring divide.
//   The accumulator is the {HI, LO} pair, 2*WIDTH bits wide.
//   Ports:
//     acc       in   2*WIDTH  current accumulator
//     operand   in   WIDTH    multiplicand (multiply) or divisor (divide)
//     op        in   1        MD_OP_MUL / MD_OP_DIV
//     acc_next  out  2*WIDTH  accumulator after this iteration
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               op,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_rem;
  logic [WIDTH:0] div_diff;

  // Multiply: the carry out of the upper-half add becomes the new MSB as the
  // whole pair shifts right, so no product bit is lost.
  // Divide: the partial remainder is one bit wider than the divisor after the
  // left shift; bit WIDTH of the difference is the borrow, i.e. "negative".
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      mul_sum = mul_sum + {1'b0, operand};
    end
    div_rem  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, operand};

    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (op == MD_OP_DIV) begin
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit next to the EX stage. Owns HI/LO, runs a
//   WIDTH-cycle shift-add multiply or restoring divide, and asks the pipeline
//   controller to stall when a new mul/div or an HI/LO read arrives while busy.
//   Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV via op_signed).
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     start        EX holds a mul/div, operands valid this cycle
//     op           MD_OP_MUL (MULTU) / MD_OP_DIV (DIVU)
//     op_signed    signed variant, only honoured with MULDIV_SIGNED_EN
//     src_a/src_b  multiplicand-dividend / multiplier-divisor
//     kill         pipeline flush, aborts an in-flight operation
//     hilo_read    ID reads HI or LO this cycle
//     busy         operation running
//     done         HI/LO written this cycle
//     stall_pipe   busy & (start | hilo_read)
//     hi/lo        HI and LO registers (with write bypass during DONE)
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             stall_pipe,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_step, acc_load, prod_res;
  logic [WIDTH-1:0]   operand, operand_load;
  logic [WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               op_q;
  logic               neg_lo_q, neg_hi_q, neg_lo_load, neg_hi_load;
  logic               accept, div0;

  assign div0 = (op == MD_OP_DIV) && (src_b == '0);

`ifdef MULDIV_SIGNED_EN
  // Signed operations iterate on magnitudes; the signs are remembered and
  // applied to the result in DONE. For multiply neg_lo covers the whole product.
  logic a_neg, b_neg;
  assign a_neg       = op_signed & src_a[WIDTH-1];
  assign b_neg       = op_signed & src_b[WIDTH-1];
  assign a_mag       = a_neg ? -src_a : src_a;
  assign b_mag       = b_neg ? -src_b : src_b;
  assign neg_lo_load = a_neg ^ b_neg;
  assign neg_hi_load = a_neg;
`else
  logic unused_signed;
  assign unused_signed = op_signed;
  assign a_mag         = src_a;
  assign b_mag         = src_b;
  assign neg_lo_load   = 1'b0;
  assign neg_hi_load   = 1'b0;
`endif

  // Initial accumulator: the multiplier (or dividend) sits in LO with HI
  // cleared. Divide by zero preloads the fixed result and skips RUN.
  always_comb begin
    acc_load     = {{WIDTH{1'b0}}, b_mag};
    operand_load = a_mag;
    if (op == MD_OP_DIV) begin
      acc_load     = {{WIDTH{1'b0}}, a_mag};
      operand_load = b_mag;
    end
    if (div0) begin
      acc_load = {src_a, {WIDTH{1'b1}}};
    end
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .operand (operand),
    .op      (op_q),
    .acc_next(acc_step)
  );

  // Sign correction of the finished accumulator; this is what gets written
  // to HI/LO and what the bypass shows while in DONE.
  always_comb begin
    prod_res = neg_lo_q ? -acc : acc;
    res_hi   = prod_res[2*WIDTH-1:WIDTH];
    res_lo   = prod_res[WIDTH-1:0];
    if (op_q == MD_OP_DIV) begin
      res_lo = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start is taken from IDLE or DONE unless kill drops it; a kill in DONE
  // is harmless because the HI/LO write happens in that cycle regardless.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (start && !kill) begin
          accept     = 1'b1;
          state_next = div0 ? MD_DONE : MD_RUN;
        end
      end
      MD_RUN: begin
        if (kill) begin
          state_next = MD_IDLE;
        end else if (count == LAST) begin
          state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        state_next = MD_IDLE;
        if (start && !kill) begin
          accept     = 1'b1;
          state_next = div0 ? MD_DONE : MD_RUN;
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      op_q     <= MD_OP_MUL;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (state == MD_DONE) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (accept) begin
        acc      <= acc_load;
        operand  <= operand_load;
        op_q     <= op;
        neg_lo_q <= neg_lo_load & !div0;
        neg_hi_q <= neg_hi_load & !div0 & (op == MD_OP_DIV);
        count    <= '0;
      end else if (state == MD_RUN) begin
        acc   <= acc_step;
        count <= count + CW'(1);
      end
    end
  end

  assign busy       = (state == MD_RUN);
  assign done       = (state == MD_DONE);
  assign stall_pipe = busy & (start | hilo_read);
  assign hi         = (state == MD_DONE) ? res_hi : hi_q;
  assign lo         = (state == MD_DONE) ? res_lo : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed, table-driven bench for muldiv_sequencer (WIDTH = 32), plus
//   hand-written sequences for stall, kill, start-in-DONE and reset corners.
//   Expectations follow MULDIV_SIGNED_EN when the bench is built with it.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, op, op_signed, kill, hilo_read;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, stall_pipe;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        opv;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .op_signed (op_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .kill      (kill),
    .hilo_read (hilo_read),
    .busy      (busy),
    .done      (done),
    .stall_pipe(stall_pipe),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives start for one cycle from the current cycle T and waits (bounded)
  // for done; lat is the cycle offset from T where done was seen.
  task automatic applyStimulus(input logic opv, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    op        = opv;
    op_signed = sgn;
    src_a     = a;
    src_b     = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic vec_t mkVec(input string name, input logic opv, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eh, input logic [31:0] el,
                                 input int lat);
    vec_t v;
    v.name = name; v.opv = opv; v.sgn = sgn; v.a = a; v.b = b;
    v.exp_hi = eh; v.exp_lo = el; v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lat2, n, pulses;

    vecs.push_back(mkVec("multu_ffff_x2",  MD_OP_MUL, 1'b0, 32'hFFFFFFFF, 32'h2,     32'h1,        32'hFFFFFFFE, 33));
    vecs.push_back(mkVec("divu_100_7",     MD_OP_DIV, 1'b0, 32'd100,      32'd7,     32'd2,        32'd14,       33));
    vecs.push_back(mkVec("divu_5_0",       MD_OP_DIV, 1'b0, 32'd5,        32'd0,     32'd5,        32'hFFFFFFFF, 1));
    vecs.push_back(mkVec("multu_shift16",  MD_OP_MUL, 1'b0, 32'h12345678, 32'h10,    32'h1,        32'h23456780, 33));
    vecs.push_back(mkVec("multu_max_max",  MD_OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33));
    vecs.push_back(mkVec("divu_max_1",     MD_OP_DIV, 1'b0, 32'hFFFFFFFF, 32'd1,     32'h0,        32'hFFFFFFFF, 33));
    vecs.push_back(mkVec("divu_small",     MD_OP_DIV, 1'b0, 32'd3,        32'd10,    32'd3,        32'd0,        33));
    vecs.push_back(mkVec("divu_deadbeef",  MD_OP_DIV, 1'b0, 32'hDEADBEEF, 32'h10000, 32'h0000BEEF, 32'h0000DEAD, 33));
    vecs.push_back(mkVec("multu_zero",     MD_OP_MUL, 1'b0, 32'h0,        32'hABCD,  32'h0,        32'h0,        33));
`ifdef MULDIV_SIGNED_EN
    vecs.push_back(mkVec("mult_m3_4",      MD_OP_MUL, 1'b1, 32'hFFFFFFFD, 32'd4,     32'hFFFFFFFF, 32'hFFFFFFF4, 33));
    vecs.push_back(mkVec("div_m7_2",       MD_OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,     32'hFFFFFFFF, 32'hFFFFFFFD, 33));
`else
    vecs.push_back(mkVec("mult_m3_4",      MD_OP_MUL, 1'b1, 32'hFFFFFFFD, 32'd4,     32'h3,        32'hFFFFFFF4, 33));
    vecs.push_back(mkVec("div_m7_2",       MD_OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,     32'h1,        32'h7FFFFFFC, 33));
`endif
    vecs.push_back(mkVec("div_m7_0",       MD_OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd0,     32'hFFFFFFF9, 32'hFFFFFFFF, 1));

    rst = 1'b1; start = 1'b0; op = MD_OP_MUL; op_signed = 1'b0;
    kill = 1'b0; hilo_read = 1'b0; src_a = '0; src_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_stall", 32'(stall_pipe), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].opv, vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({vecs[i].name, "_hi_reg"}, hi, vecs[i].exp_hi);
      checkOutput({vecs[i].name, "_lo_reg"}, lo, vecs[i].exp_lo);
    end

    // A start arriving in DONE is accepted like one from IDLE
    applyStimulus(MD_OP_MUL, 1'b0, 32'd6, 32'd7, lat);
    checkOutput("b2b_first_lo", lo, 32'd42);
    applyStimulus(MD_OP_DIV, 1'b0, 32'd100, 32'd7, lat2);
    checkOutput("b2b_first_latency", 32'(lat), 32'd33);
    checkOutput("b2b_second_latency", 32'(lat2), 32'd33);
    checkOutput("b2b_second_hi", hi, 32'd2);
    checkOutput("b2b_second_lo", lo, 32'd14);
    @(posedge clk); #1;

    // Stall on hilo_read at T+10 and on a second start at T+20
    op = MD_OP_MUL; op_signed = 1'b0; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
    #1;
    checkOutput("stall_idle_start", 32'(stall_pipe), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      hilo_read = (n == 10);
      if (n == 20) begin
        op = MD_OP_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      end
      #1;
      if (n == 10) checkOutput("stall_hilo_read", 32'(stall_pipe), 32'd1);
      if (n == 12) checkOutput("stall_no_request", 32'(stall_pipe), 32'd0);
      if (n == 20) checkOutput("stall_second_start", 32'(stall_pipe), 32'd1);
      @(posedge clk); #1;
      start = 1'b0; hilo_read = 1'b0;
      n++;
    end
    checkOutput("stall_seq_latency", 32'(n), 32'd33);
    checkOutput("stall_seq_hi", hi, 32'd0);
    checkOutput("stall_seq_lo", lo, 32'd63);
    hilo_read = 1'b1;
    #1;
    checkOutput("stall_read_in_done", 32'(stall_pipe), 32'd0);
    hilo_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_dropped_busy", 32'(busy), 32'd0);
    checkOutput("stall_dropped_lo", lo, 32'd63);

    // kill in RUN at T+5
    op = MD_OP_MUL; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill_busy_after", 32'(busy), 32'd0);
    pulses = 0;
    repeat (40) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    checkOutput("kill_no_done", 32'(pulses), 32'd0);
    checkOutput("kill_hi_kept", hi, 32'd0);
    checkOutput("kill_lo_kept", lo, 32'd63);

    // start and kill in the same cycle: start is dropped
    op = MD_OP_DIV; src_a = 32'd9; src_b = 32'd0; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    checkOutput("startkill_div0_done", 32'(done), 32'd0);
    checkOutput("startkill_div0_lo", lo, 32'd63);
    op = MD_OP_MUL; src_a = 32'd3; src_b = 32'd3; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    checkOutput("startkill_mul_busy", 32'(busy), 32'd0);

    // kill in DONE does not stop the write
    applyStimulus(MD_OP_DIV, 1'b0, 32'd100, 32'd7, lat);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill_in_done_hi", hi, 32'd2);
    checkOutput("kill_in_done_lo", lo, 32'd14);

    // reset while running clears HI/LO
    op = MD_OP_MUL; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_run_busy", 32'(busy), 32'd0);
    checkOutput("rst_run_hi", hi, 32'd0);
    checkOutput("rst_run_lo", lo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
